debouncer_multi: RTL and testbench
==================================

# debouncer_multi

Parametrised multi-channel debouncer for mechanical buttons and switches. Each channel has its own synchroniser and stability counter. Per channel, the block produces a debounced level plus one-cycle rise and fall strobes, and optionally a long-press strobe. It sits directly behind board-level pins and feeds control FSMs that need clean, edge-qualified user inputs.

## Interface
Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- STABLE_CYCLES, 1_000_000: consecutive cycles a synchronised level must hold before it is accepted (20 ms @ 50 MHz; >=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- RESET_LEVEL, 1'b0: reset value of synchroniser and debounced level; the active (pressed) level is ~RESET_LEVEL.
- LONG_CYCLES, 50_000_000: active-level hold time for a long press. Present only with DEBOUNCER_LONGPRESS_EN.

Ports:
- clock  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- bounced_i  in  CHANNELS  raw asynchronous inputs.
- debounced_o  out  CHANNELS  debounced levels.
- rise_o  out  CHANNELS  one-cycle strobe when debounced_o goes 0->1.
- fall_o  out  CHANNELS  one-cycle strobe when debounced_o goes 1->0.
- long_o  out  CHANNELS  one-cycle long-press strobe. Present only with DEBOUNCER_LONGPRESS_EN.

## Operation
- Reset values:
  - Synchroniser flops = RESET_LEVEL; debounced_o = RESET_LEVEL.
  - rise_o = fall_o = long_o = 0.
  - All counters = 0.
- Per channel, s is the last synchroniser stage and d is the debounced register.
- Stability counter cnt, width $clog2(STABLE_CYCLES+1), behaves as a two-state FSM:
  - IDLE (s==d): cnt held at 0.
  - QUALIFY (s!=d): cnt increments by 1 each edge.
  - At an edge where s!=d and cnt==STABLE_CYCLES-1: d <= s, cnt <= 0, and the matching rise/fall strobe asserts for exactly that one cycle.
  - Any edge with s==d during QUALIFY: cnt <= 0, no output change (glitch rejected).
- Strobes are registered. rise_o/fall_o are never both high on the same channel. They assert in the same cycle that debounced_o shows the new level.
- Channels are fully independent. Simultaneous events on different channels are each handled normally.
- The counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- STABLE_CYCLES==1: d follows s with one cycle of delay.
- Elaboration check: $error if CHANNELS<1, STABLE_CYCLES<1, or SYNC_STAGES<2.

## Timing
- Let k be the first edge at which stage 1 captures a new level.
- s changes at edge E = k+SYNC_STAGES-1. debounced_o and its strobe update at edge E+STABLE_CYCLES, provided s holds the new level at edges E..E+STABLE_CYCLES-1.
- Total latency = SYNC_STAGES-1+STABLE_CYCLES cycles. Example: 9 cycles for SYNC_STAGES=2, STABLE_CYCLES=8.
- Reset asserted at any time, including mid-QUALIFY: all state clears asynchronously. After reset release, a full qualification is required.
- resetn release is synchronised externally; no reset synchroniser inside.

## Configuration
- Macro: DEBOUNCER_LONGPRESS_EN.
- Defined:
  - Each channel has a hold counter of width $clog2(LONG_CYCLES+1), cleared whenever d is inactive.
  - While d is active, the counter increments and saturates at LONG_CYCLES.
  - long_o pulses one cycle at the edge where the counter reaches LONG_CYCLES, counted from the rise strobe. This happens at most once per press.
  - Release clears the counter with no strobe.
- Undefined: LONG_CYCLES parameter, long_o port and hold counters are absent; all other behaviour is identical.

## Structure
- Package debouncer_pkg holds:
  - Default constants: DEFAULT_STABLE_CYCLES, DEFAULT_SYNC_STAGES, DEFAULT_LONG_CYCLES.
  - A function clog2_min1(n) returning at least 1 for counter widths.
- Sub-module debouncer_channel implements one channel: synchroniser, stability FSM, strobes, optional hold counter. debouncer_multi is a generate loop of CHANNELS instances.

## Test plan
All scenarios use CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=8, LONG_CYCLES=20 (macro defined), 50 MHz clock.
- Reset: hold resetn low 5 cycles while toggling bounced_i every cycle -> all outputs 0 throughout and 0 at release.
- Clean step: bounced_i[0] 0->1 captured at edge k and held -> debounced_o[0]=1 and rise_o[0]=1 at edge k+9. rise_o[0] is low at edge k+10. No other channel changes.
- Bounce then settle: bounced_i[1] alternates with a 3-cycle period for 40 cycles, then stays 1 -> exactly one rise_o[1] pulse, 9 cycles after the final capture. The same test with 1->0 checks fall_o[1].
- Threshold: a synchronised pulse of 7 cycles on ch2 -> no change. A pulse of 8 cycles -> rise_o[2]. Its release 8 cycles later -> fall_o[2].
- Concurrency and reset mid-qualify:
  - ch2 and ch3 change on the same edge -> independent strobes in the same cycle.
  - ch0 is at cnt=5 when resetn pulses low -> outputs 0. After release, the full 9-cycle latency applies again.
- Long press: ch0 held active 30 cycles after rise_o -> a single long_o[0] pulse 20 cycles after rise_o[0]. A release before 20 cycles -> no long_o.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared defaults, stability FSM encoding and counter-width helper for debouncer_multi.
// The optional long-press feature is enabled with DEBOUNCER_LONGPRESS_EN.
package debouncer_pkg;

   localparam int DEFAULT_STABLE_CYCLES = 1_000_000;
   localparam int DEFAULT_SYNC_STAGES   = 2;
   localparam int DEFAULT_LONG_CYCLES   = 50_000_000;

   typedef enum logic {
      ST_IDLE,
      ST_QUALIFY
   } qual_state_t;

   // Counter widths must stay at least one bit even for tiny thresholds.
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debouncer_channel.sv
// One debouncer channel: synchroniser, stability-qualify FSM, edge strobes and,
// with DEBOUNCER_LONGPRESS_EN defined, a saturating long-press hold counter.
module debouncer_channel
   import debouncer_pkg::*;
#(
   parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter logic RESET_LEVEL   = 1'b0
`ifdef DEBOUNCER_LONGPRESS_EN
   ,parameter int  LONG_CYCLES   = DEFAULT_LONG_CYCLES
`endif
) (
   input  logic clock,
   input  logic resetn,
   input  logic bounced,
   output logic debounced,
   output logic rise,
   output logic fall
`ifdef DEBOUNCER_LONGPRESS_EN
   ,output logic long_press
`endif
);

   localparam int               CNT_W    = clog2_min1(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   qual_state_t            state;
   qual_state_t            state_next;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_next;
   logic                   accept;
   logic                   d_next;
   logic                   rise_next;
   logic                   fall_next;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], bounced};
      end
   end

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         debounced <= RESET_LEVEL;
         rise      <= 1'b0;
         fall      <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         debounced <= d_next;
         rise      <= rise_next;
         fall      <= fall_next;
      end
   end

   // In IDLE the counter is known to be zero, so a single-cycle threshold accepts immediately.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      d_next     = debounced;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (s != debounced) begin
               if (STABLE_CYCLES == 1) begin
                  accept = 1'b1;
               end else begin
                  cnt_next   = CNT_W'(1);
                  state_next = ST_QUALIFY;
               end
            end
         end
         ST_QUALIFY: begin
            if (s == debounced) begin
               cnt_next   = '0;
               state_next = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
               accept = 1'b1;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = ST_IDLE;
         end
      endcase
      if (accept) begin
         d_next     = s;
         cnt_next   = '0;
         rise_next  = s;
         fall_next  = ~s;
         state_next = ST_IDLE;
      end
   end

`ifdef DEBOUNCER_LONGPRESS_EN
   localparam int                HOLD_W   = clog2_min1(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

   logic [HOLD_W-1:0] hold;
   logic              active;

   assign active = (debounced != RESET_LEVEL);

   // Saturation at HOLD_MAX is what limits the strobe to one per press.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hold       <= '0;
         long_press <= 1'b0;
      end else if (!active) begin
         hold       <= '0;
         long_press <= 1'b0;
      end else if (hold != HOLD_MAX) begin
         hold       <= hold + HOLD_W'(1);
         long_press <= (hold == HOLD_MAX - HOLD_W'(1));
      end else begin
         long_press <= 1'b0;
      end
   end
`endif

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer top: one independent debouncer_channel per input bit.
// Define DEBOUNCER_LONGPRESS_EN to add the LONG_CYCLES parameter and long_o strobes.
module debouncer_multi
   import debouncer_pkg::*;
#(
   parameter int   CHANNELS      = 4,
   parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter logic RESET_LEVEL   = 1'b0
`ifdef DEBOUNCER_LONGPRESS_EN
   ,parameter int  LONG_CYCLES   = DEFAULT_LONG_CYCLES
`endif
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [CHANNELS-1:0] bounced_i,
   output logic [CHANNELS-1:0] debounced_o,
   output logic [CHANNELS-1:0] rise_o,
   output logic [CHANNELS-1:0] fall_o
`ifdef DEBOUNCER_LONGPRESS_EN
   ,output logic [CHANNELS-1:0] long_o
`endif
);

   if (CHANNELS < 1 || STABLE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_param_check
      $error("debouncer_multi: need CHANNELS>=1, STABLE_CYCLES>=1, SYNC_STAGES>=2");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debouncer_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .SYNC_STAGES   (SYNC_STAGES),
         .RESET_LEVEL   (RESET_LEVEL)
`ifdef DEBOUNCER_LONGPRESS_EN
         ,.LONG_CYCLES  (LONG_CYCLES)
`endif
      ) u_ch (
         .clock      (clock),
         .resetn     (resetn),
         .bounced    (bounced_i[i]),
         .debounced  (debounced_o[i]),
         .rise       (rise_o[i]),
         .fall       (fall_o[i])
`ifdef DEBOUNCER_LONGPRESS_EN
         ,.long_press (long_o[i])
`endif
      );
   end

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi (4 channels, 2 sync stages, 8 stable cycles, long press 20).
// Long-press expectations are only issued when DEBOUNCER_LONGPRESS_EN is defined.
module tb_debouncer_multi;

   localparam int LAT = 10;
   localparam int LC  = 20;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] bounced = 4'b0000;
   logic [3:0] debounced_o;
   logic [3:0] rise_o;
   logic [3:0] fall_o;
   logic [3:0] long_w;

   typedef struct {
      int         at;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] lng;
      logic [3:0] deb;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [3:0] exp_deb = 4'b0000;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;

   always #10 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   debouncer_multi #(
      .CHANNELS      (4),
      .STABLE_CYCLES (8),
      .SYNC_STAGES   (2),
      .RESET_LEVEL   (1'b0)
`ifdef DEBOUNCER_LONGPRESS_EN
      ,.LONG_CYCLES  (LC)
`endif
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .bounced_i   (bounced),
      .debounced_o (debounced_o),
      .rise_o      (rise_o),
      .fall_o      (fall_o)
`ifdef DEBOUNCER_LONGPRESS_EN
      ,.long_o     (long_w)
`endif
   );

`ifndef DEBOUNCER_LONGPRESS_EN
   assign long_w = 4'b0000;
`endif

   // Monitor: every strobe cycle must match the next queued expectation exactly.
   always @(negedge clock) begin
      if (resetn && ((rise_o | fall_o | long_w) != 4'b0000)) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_strobe: cyc=%0d rise=%b fall=%b long=%b deb=%b, required no strobe",
                     cyc, rise_o, fall_o, long_w, debounced_o);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.at != cyc || rise_o !== mon_e.rise || fall_o !== mon_e.fall ||
                long_w !== mon_e.lng || debounced_o !== mon_e.deb) begin
               bad++;
               $display("[TB] FAIL strobe_event: got cyc=%0d rise=%b fall=%b long=%b deb=%b, required cyc=%0d rise=%b fall=%b long=%b deb=%b",
                        cyc, rise_o, fall_o, long_w, debounced_o,
                        mon_e.at, mon_e.rise, mon_e.fall, mon_e.lng, mon_e.deb);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic expect_event(input int at, input logic [3:0] r, input logic [3:0] f, input logic [3:0] l);
      exp_t e;
      exp_deb = (exp_deb | r) & ~f;
      e.at   = at;
      e.rise = r;
      e.fall = f;
      e.lng  = l;
      e.deb  = exp_deb;
      sb.push_back(e);
   endtask

   task automatic expect_long(input int at, input logic [3:0] l);
`ifdef DEBOUNCER_LONGPRESS_EN
      expect_event(at, 4'b0000, 4'b0000, l);
`else
      if (at < 0 || l == 4'b0000) $display("[TB] note: unused long expectation");
`endif
   endtask

   task automatic apply_stimulus(input logic [3:0] val);
      bounced = val;
   endtask

   task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %b required %b", name, act, req);
      end
   endtask

   initial begin
      int r;
      // Reset with input toggling every cycle
      resetn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         apply_stimulus(~bounced);
         check_output("reset_debounced", debounced_o, 4'b0000);
         check_output("reset_strobes", rise_o | fall_o | long_w, 4'b0000);
      end
      @(negedge clock);
      apply_stimulus(4'b0000);
      resetn = 1'b1;
      check_output("release_debounced", debounced_o, 4'b0000);
      check_output("release_strobes", rise_o | fall_o | long_w, 4'b0000);
      step(12);

      // Clean step on ch0, then back down
      apply_stimulus(4'b0001);
      expect_event(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
      step(12);
      check_output("step_level", debounced_o, 4'b0001);
      apply_stimulus(4'b0000);
      expect_event(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
      step(12);

      // Bounce then settle high on ch1
      for (int i = 0; i < 40; i++) begin
         bounced[1] = ((i / 3) % 2 == 0);
         step(1);
      end
      bounced[1] = 1'b1;
      r = cyc + LAT;
      expect_event(r, 4'b0010, 4'b0000, 4'b0000);
      expect_long(r + LC, 4'b0010);
      step(12);
      // Bounce then settle low on ch1
      for (int i = 0; i < 40; i++) begin
         bounced[1] = ((i / 3) % 2 != 0);
         step(1);
      end
      bounced[1] = 1'b0;
      expect_event(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
      step(12);

      // Threshold on ch2: 7-cycle pulse rejected, 8-cycle pulse accepted
      bounced[2] = 1'b1;
      step(7);
      bounced[2] = 1'b0;
      step(12);
      check_output("short_pulse_level", debounced_o, 4'b0000);
      bounced[2] = 1'b1;
      expect_event(cyc + LAT, 4'b0100, 4'b0000, 4'b0000);
      step(8);
      bounced[2] = 1'b0;
      expect_event(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
      step(12);

      // Simultaneous ch2 and ch3
      apply_stimulus(4'b1100);
      expect_event(cyc + LAT, 4'b1100, 4'b0000, 4'b0000);
      step(12);
      apply_stimulus(4'b0000);
      expect_event(cyc + LAT, 4'b0000, 4'b1100, 4'b0000);
      step(12);

      // Reset pulse while ch0 is mid-qualify (cnt=5)
      apply_stimulus(4'b0001);
      step(7);
      resetn = 1'b0;
      step(1);
      check_output("midreset_debounced", debounced_o, 4'b0000);
      check_output("midreset_strobes", rise_o | fall_o | long_w, 4'b0000);
      step(1);
      resetn = 1'b1;
      r = cyc + LAT;
      expect_event(r, 4'b0001, 4'b0000, 4'b0000);
      expect_long(r + LC, 4'b0001);

      // Long press: hold 30 cycles past the rise, then a short press
      step(LAT + 30);
      apply_stimulus(4'b0000);
      expect_event(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
      step(12);
      check_output("long_release_level", debounced_o, 4'b0000);
      apply_stimulus(4'b0001);
      expect_event(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
      step(15);
      apply_stimulus(4'b0000);
      expect_event(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
      step(40);

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL pending_events: got %0d outstanding required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
